// File: rtl/path_replayer_if.sv
// path_replayer_if: solver-stack, replay request and move-output bundle for path_replayer
//   solve_done, run           request side (driven by master)
//   stk_empty, stk_loc        solver stack view (driven by master)
//   stk_pop                   stack pop strobe (driven by slave)
//   move, loc_out, dir_out    paced move pulses (driven by slave)
//   busy, replay_done, err    status (driven by slave)
interface path_replayer_if #(parameter int LOC_W = 8);
    logic             solve_done;
    logic             run;
    logic             stk_empty;
    logic [LOC_W-1:0] stk_loc;
    logic             stk_pop;
    logic             move;
    logic [LOC_W-1:0] loc_out;
    logic [1:0]       dir_out;
    logic             busy;
    logic             replay_done;
    logic             err;
    modport master (
        output solve_done, run, stk_empty, stk_loc,
        input  stk_pop, move, loc_out, dir_out, busy, replay_done, err
    );
    modport slave (
        input  solve_done, run, stk_empty, stk_loc,
        output stk_pop, move, loc_out, dir_out, busy, replay_done, err
    );
endinterface

// File: rtl/path_replayer.sv
// path_replayer: drains the solver's LIFO path stack and replays it start-to-goal as paced moves
//   clk, rst  clock and asynchronous active-high reset
//   bus       path_replayer_if slave: stack in/pop out, move/loc/dir out, busy/replay_done/err
//   loc = {row, col}; dir 00 up, 01 right, 10 left, 11 down
module path_replayer #(
    parameter int LOC_W    = 8,
    parameter int DEPTH    = 256,
    parameter int STEP_CYC = 4
) (
    input logic            clk,
    input logic            rst,
    path_replayer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int HW = LOC_W / 2;
    localparam int CW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'((STEP_CYC > 1) ? STEP_CYC - 2 : 0);
    localparam logic [HW:0]   ONE = (HW+1)'(1);

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, WAIT, FIN} state_t;

    state_t           r_state;
    logic [AW:0]      r_wr;
    logic [AW-1:0]    r_rd;
    logic [LOC_W-1:0] r_prev;
    logic             r_first;
    logic [CW-1:0]    r_cnt;
    logic             r_move;
    logic [LOC_W-1:0] r_loc;
    logic [1:0]       r_dir;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [LOC_W-1:0] r_buf [DEPTH];

    logic             w_pop;
    logic [LOC_W-1:0] w_cur;
    logic [HW:0]      w_cr, w_cc, w_pr, w_pc;
    logic             w_up, w_right, w_left, w_down, w_adj;
    logic [1:0]       w_dir;

    // pop only while there is room; a full buffer with data still waiting is an overflow
    assign w_pop = (r_state == LOAD) && !bus.stk_empty && (r_wr != (AW+1)'(DEPTH));
    assign w_cur = r_buf[r_rd];

    // one extra bit keeps 0-1 and 15+1 from wrapping into a false adjacency
    assign w_cr = {1'b0, w_cur[LOC_W-1 -: HW]};
    assign w_cc = {1'b0, w_cur[HW-1:0]};
    assign w_pr = {1'b0, r_prev[LOC_W-1 -: HW]};
    assign w_pc = {1'b0, r_prev[HW-1:0]};
    assign w_up    = (w_cc == w_pc) && (w_cr + ONE == w_pr);
    assign w_down  = (w_cc == w_pc) && (w_pr + ONE == w_cr);
    assign w_right = (w_cr == w_pr) && (w_pc + ONE == w_cc);
    assign w_left  = (w_cr == w_pr) && (w_cc + ONE == w_pc);
    assign w_adj   = w_up | w_down | w_right | w_left;
    assign w_dir   = {w_left | w_down, w_right | w_down};

    assign bus.stk_pop     = w_pop;
    assign bus.move        = r_move;
    assign bus.loc_out     = r_loc;
    assign bus.dir_out     = r_dir;
    assign bus.busy        = r_busy;
    assign bus.replay_done = r_done;
    assign bus.err         = r_err;

    always_ff @(posedge clk) begin
        if (w_pop) r_buf[r_wr[AW-1:0]] <= bus.stk_loc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_wr    <= '0;
            r_rd    <= '0;
            r_prev  <= '0;
            r_first <= 1'b0;
            r_cnt   <= '0;
            r_move  <= 1'b0;
            r_loc   <= '0;
            r_dir   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_move <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.run && bus.solve_done) begin
                    r_state <= LOAD;
                    r_busy  <= 1'b1;
                    r_err   <= 1'b0;
                    r_wr    <= '0;
                end
                LOAD: if (w_pop) begin
                    r_wr <= r_wr + (AW+1)'(1);
                end else if (!bus.stk_empty) begin
                    r_err   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= FIN;
                end else if (r_wr == '0) begin
                    r_busy  <= 1'b0;
                    r_state <= FIN;
                end else begin
                    r_rd    <= AW'(r_wr - (AW+1)'(1));
                    r_first <= 1'b1;
                    r_state <= PLAY;
                end
                PLAY: if (r_first) begin
                    // start cell: latch it as the reference, no move pulse
                    r_prev  <= w_cur;
                    r_first <= 1'b0;
                    if (r_rd == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= FIN;
                    end else begin
                        r_rd <= r_rd - AW'(1);
                    end
                end else if (w_adj) begin
                    r_move <= 1'b1;
                    r_loc  <= w_cur;
                    r_dir  <= w_dir;
                    r_prev <= w_cur;
                    if (r_rd == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= FIN;
                    end else begin
                        r_rd    <= r_rd - AW'(1);
                        r_cnt   <= '0;
                        r_state <= (STEP_CYC > 1) ? WAIT : PLAY;
                    end
                end else begin
                    r_err   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= FIN;
                end
                WAIT: if (r_cnt == WAIT_LAST) r_state <= PLAY;
                      else r_cnt <= r_cnt + CW'(1);
                FIN: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_path_replayer.sv
// tb_path_replayer: directed checks of path_replayer with a LIFO stack model and a 4-entry buffer
module tb_path_replayer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_push = 0;
    int   n_pop = 0;
    int   n_move = 0;
    logic [7:0] sarr [0:63];

    path_replayer_if #(.LOC_W(8)) bus ();

    path_replayer #(.LOC_W(8), .DEPTH(4), .STEP_CYC(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.stk_empty = (n_push == n_pop);
        bus.stk_loc   = (n_push > n_pop) ? sarr[n_push - n_pop - 1] : 8'h00;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.stk_pop) n_pop <= n_pop + 1;
        if (bus.move) n_move <= n_move + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        sarr[n_push - n_pop] = v;
        n_push++;
    endtask

    task automatic pulse_run();
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
    endtask

    task automatic wait_move(input string tag, output int c);
        int k = 0;
        @(negedge clk);
        while (!bus.move && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk(tag, bus.move, 1);
        c = cyc;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        @(negedge clk);
        while (!bus.replay_done && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk(tag, bus.replay_done, 1);
    endtask

    initial begin
        int c0, c1, c2, p, m, q;
        bus.run = 1'b0;
        bus.solve_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_move", bus.move, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.replay_done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_loc", bus.loc_out, 0);
        chk("rst_dir", bus.dir_out, 0);
        rst = 1'b0;
        @(negedge clk);

        // path 00 -> 01 -> 11 -> 12, goal pushed last; run without solve_done is ignored
        push(8'h00); push(8'h01); push(8'h11); push(8'h12);
        pulse_run();
        chk("nosolve_busy", bus.busy, 0);
        chk("nosolve_pop", bus.stk_pop, 0);
        @(negedge clk);
        chk("nosolve_depth", n_push - n_pop, 4);
        bus.solve_done = 1'b1;
        pulse_run();
        chk("t1_busy", bus.busy, 1);
        p = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.stk_pop) p++;
            @(negedge clk);
        end
        chk("t1_pops", p, 4);
        chk("t1_pop_end", bus.stk_pop, 0);
        wait_move("t1_m0", c0);
        chk("t1_m0_loc", bus.loc_out, 8'h01);
        chk("t1_m0_dir", bus.dir_out, 2'b01);
        wait_move("t1_m1", c1);
        chk("t1_m1_loc", bus.loc_out, 8'h11);
        chk("t1_m1_dir", bus.dir_out, 2'b11);
        chk("t1_gap1", c1 - c0, 4);
        wait_move("t1_m2", c2);
        chk("t1_m2_loc", bus.loc_out, 8'h12);
        chk("t1_m2_dir", bus.dir_out, 2'b01);
        chk("t1_gap2", c2 - c1, 4);
        @(negedge clk);
        chk("t1_done", bus.replay_done, 1);
        chk("t1_err", bus.err, 0);
        @(negedge clk);
        chk("t1_done_pulse", bus.replay_done, 0);
        chk("t1_idle", bus.busy, 0);
        chk("t1_hold_loc", bus.loc_out, 8'h12);

        // column gap 00 -> 02
        m = n_move;
        push(8'h00); push(8'h02);
        pulse_run();
        wait_done("t4_done");
        chk("t4_err", bus.err, 1);
        chk("t4_moves", n_move - m, 0);

        // row 0 -> 15 must not wrap into adjacency
        push(8'h00); push(8'hF0);
        pulse_run();
        wait_done("wrap_done");
        chk("wrap_err", bus.err, 1);
        chk("wrap_moves", n_move - m, 0);

        // err is sticky through idle cycles and an ignored run
        repeat (3) @(negedge clk);
        bus.solve_done = 1'b0;
        pulse_run();
        chk("sticky_err", bus.err, 1);
        chk("sticky_busy", bus.busy, 0);

        // empty stack: accepted run clears err, busy one cycle, done two cycles after run
        bus.solve_done = 1'b1;
        pulse_run();
        chk("t2_busy", bus.busy, 1);
        chk("t2_err_clr", bus.err, 0);
        chk("t2_pop", bus.stk_pop, 0);
        @(negedge clk);
        chk("t2_busy_low", bus.busy, 0);
        chk("t2_done_early", bus.replay_done, 0);
        @(negedge clk);
        chk("t2_done", bus.replay_done, 1);
        chk("t2_moves", n_move - m, 0);

        // overflow: 5 entries into a 4-entry buffer
        q = n_pop;
        push(8'h30); push(8'h55); push(8'h55); push(8'h55); push(8'h55);
        pulse_run();
        wait_done("t5_done");
        chk("t5_err", bus.err, 1);
        chk("t5_pops", n_pop - q, 4);
        chk("t5_left", n_push - n_pop, 1);
        chk("t5_moves", n_move - m, 0);

        // reset in WAIT after the second move of 30 -> 31 -> 32 -> 33
        push(8'h31); push(8'h32); push(8'h33);
        pulse_run();
        wait_move("t6_m0", c0);
        chk("t6_m0_loc", bus.loc_out, 8'h31);
        wait_move("t6_m1", c1);
        chk("t6_m1_loc", bus.loc_out, 8'h32);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_move", bus.move, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_loc", bus.loc_out, 0);
        chk("t6_rst_dir", bus.dir_out, 0);
        chk("t6_rst_err", bus.err, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_empty", bus.stk_empty, 1);

        // fresh path 40 -> 41 -> 31 -> 30 covers right, up and left
        m = n_move;
        push(8'h40); push(8'h41); push(8'h31); push(8'h30);
        pulse_run();
        wait_move("t6_n0", c0);
        chk("t6_n0_loc", bus.loc_out, 8'h41);
        chk("t6_n0_dir", bus.dir_out, 2'b01);
        wait_move("t6_n1", c1);
        chk("t6_n1_loc", bus.loc_out, 8'h31);
        chk("t6_n1_dir", bus.dir_out, 2'b00);
        wait_move("t6_n2", c2);
        chk("t6_n2_loc", bus.loc_out, 8'h30);
        chk("t6_n2_dir", bus.dir_out, 2'b10);
        wait_done("t6_done");
        chk("t6_moves", n_move - m, 3);
        chk("t6_err", bus.err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
